// File: rtl/des_pkg.sv
// Shared DES constants for the round controller: FIPS 46-3 permutation tables,
// key-rotation schedule, FSM state encoding and the permutation helpers.
package des_pkg;

  localparam int DES_BLK    = 64;
  localparam int DES_HALF   = 32;
  localparam int DES_CD     = 28;
  localparam int DES_SUBKEY = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } des_state_e;

  // Tables use DES bit numbering: entry n names source bit n, bit 1 = MSB.
  localparam int IP_TAB [DES_BLK] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int PC1_TAB [2*DES_CD] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [DES_SUBKEY] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotation amount for encrypt rounds 1..16 (index = round - 1).
  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [1:DES_BLK] des_ip(input logic [1:DES_BLK] blk);
    logic [1:DES_BLK] res;
    for (int i = 0; i < DES_BLK; i++) res[i+1] = blk[IP_TAB[i]];
    return res;
  endfunction

  function automatic logic [1:2*DES_CD] des_pc1(input logic [1:DES_BLK] key);
    logic [1:2*DES_CD] res;
    for (int i = 0; i < 2*DES_CD; i++) res[i+1] = key[PC1_TAB[i]];
    return res;
  endfunction

  function automatic logic [1:DES_SUBKEY] des_pc2(input logic [1:2*DES_CD] cd);
    logic [1:DES_SUBKEY] res;
    for (int i = 0; i < DES_SUBKEY; i++) res[i+1] = cd[PC2_TAB[i]];
    return res;
  endfunction

  function automatic logic [1:DES_CD] rotl28(input logic [1:DES_CD] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[2:DES_CD], x[1]};
      2'd2:    return {x[3:DES_CD], x[1:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [1:DES_CD] rotr28(input logic [1:DES_CD] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[DES_CD], x[1:DES_CD-1]};
      2'd2:    return {x[DES_CD-1:DES_CD], x[1:DES_CD-2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_key_sched.sv
// DES key schedule: holds C/D, presents this round's rotated halves through
// PC-2 as the subkey, and commits the rotation when the round advances.
module des_key_sched
  import des_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic                  mode,
  input  logic [3:0]            rnd,
  input  logic [1:DES_BLK]      key,
  output logic [1:DES_SUBKEY]   f_k
);

  logic [1:DES_CD]   c_q, d_q;
  logic [1:DES_CD]   c_rot, d_rot;
  logic [1:2*DES_CD] cd_load;
  logic [1:0]        amt;
  logic [3:0]        dec_idx;

  assign cd_load = des_pc1(key);

  // Decrypt round rnd+1 undoes encrypt shift s[17-rnd]; that table index is
  // 16-rnd, i.e. (0 - rnd) mod 16. Round 1 (rnd=0) needs no rotation.
  assign dec_idx = 4'd0 - rnd;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    amt   = 2'd0;
    c_rot = c_q;
    d_rot = d_q;
    if (!mode) begin
      amt   = SHIFT_TAB[rnd];
      c_rot = rotl28(c_q, amt);
      d_rot = rotl28(d_q, amt);
    end else begin
      if (rnd != 4'd0) amt = SHIFT_TAB[dec_idx];
      c_rot = rotr28(c_q, amt);
      d_rot = rotr28(d_q, amt);
    end
  end

  assign f_k = des_pc2({c_rot, d_rot});

  // NOTE: sequential state is written with <= so all flops sample the
  // pre-edge values; blocking '=' stays in the combinational blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      d_q <= '0;
    end else if (load) begin
      c_q <= cd_load[1:DES_CD];
      d_q <= cd_load[DES_CD+1:2*DES_CD];
    end else if (step) begin
      c_q <= c_rot;
      d_q <= d_rot;
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round controller: IP on acceptance, sixteen Feistel rounds
// through an external f-function, then holds R16||L16 until taken downstream.
module des_round_ctrl
  import des_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:DES_BLK]      in_data,
  input  logic [1:DES_BLK]      in_key,
  input  logic                  decrypt,
  output logic [1:DES_HALF]     f_r,
  output logic [1:DES_SUBKEY]   f_k,
  input  logic [1:DES_HALF]     f_out,
  output logic [3:0]            round_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:DES_BLK]      out_data
);

  des_state_e          state_q, state_d;
  logic [1:DES_HALF]   l_q, l_d;
  logic [1:DES_HALF]   r_q, r_d;
  logic [3:0]          rnd_q, rnd_d;
  logic                mode_q, mode_d;
  logic [1:DES_BLK]    ip_blk;
  logic                accept;
  logic                step;

  assign ip_blk = des_ip(in_data);
  assign accept = in_valid && (state_q == IDLE);
  assign step   = (state_q == ROUND);

  des_key_sched u_key_sched (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (step),
    .mode  (mode_q),
    .rnd   (rnd_q),
    .key   (in_key),
    .f_k   (f_k)
  );

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    rnd_d   = rnd_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ROUND;
          l_d     = ip_blk[1:DES_HALF];
          r_d     = ip_blk[DES_HALF+1:DES_BLK];
          rnd_d   = 4'd0;
          mode_d  = decrypt;
        end
      end
      ROUND: begin
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      rnd_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      rnd_q   <= rnd_d;
      mode_q  <= mode_d;
    end
  end

  // Handshake outputs decode registered state only; no path from in_valid/out_ready.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign round_idx = (state_q == ROUND) ? rnd_q : 4'd0;
  assign f_r       = r_q;
  assign out_data  = {r_q, l_q};

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl: behavioural f-function plus an
// independent full-DES reference feeding a scoreboard of pre-output values.
module tb_des_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:64] in_data;
  logic [1:64] in_key;
  logic        decrypt;
  logic [1:32] f_r;
  logic [1:48] f_k;
  logic [1:32] f_out;
  logic [3:0]  round_idx;
  logic        out_valid;
  logic        out_ready;
  logic [1:64] out_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:64] sb_q [$];

  localparam logic [1:64] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [1:64] PT_A  = 64'h0123456789ABCDEF;
  localparam logic [1:64] CT_A  = 64'h85E813540F0AB405;

  localparam int TB_IP [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int TB_FP [64] = '{
    40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int TB_PC1 [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int TB_PC2 [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int TB_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int TB_E [48] = '{
    32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int TB_P [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int TB_S [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [1:32] f_model(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s;
    logic [1:32] o;
    logic [5:0]  six;
    int          row, col, v;
    for (int i = 0; i < 48; i++) x[i+1] = r[TB_E[i]] ^ k[i+1];
    for (int b = 0; b < 8; b++) begin
      for (int t = 0; t < 6; t++) six[5-t] = x[6*b+1+t];
      row = {six[5], six[0]};
      col = six[4:1];
      v   = TB_S[b][row*16 + col];
      for (int t = 0; t < 4; t++) s[4*b+1+t] = v[3-t];
    end
    for (int i = 0; i < 32; i++) o[i+1] = s[TB_P[i]];
    return o;
  endfunction

  function automatic logic [1:64] fp_model(input logic [1:64] x);
    logic [1:64] o;
    for (int i = 0; i < 64; i++) o[i+1] = x[TB_FP[i]];
    return o;
  endfunction

  // Reference: all 16 subkeys generated up front, decrypt walks them backwards.
  function automatic logic [1:64] ref_pre(input logic [1:64] blk, input logic [1:64] key,
                                          input logic dec);
    logic [1:56] cd;
    logic [1:28] c, d;
    logic [1:48] ks [16];
    logic [1:64] ipb;
    logic [1:32] l, r, t;
    for (int i = 0; i < 56; i++) cd[i+1] = key[TB_PC1[i]];
    c = cd[1:28];
    d = cd[29:56];
    for (int j = 0; j < 16; j++) begin
      for (int n = 0; n < TB_SHIFT[j]; n++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[j][i+1] = cd[TB_PC2[i]];
    end
    for (int i = 0; i < 64; i++) ipb[i+1] = blk[TB_IP[i]];
    l = ipb[1:32];
    r = ipb[33:64];
    for (int j = 0; j < 16; j++) begin
      t = r;
      r = l ^ f_model(r, dec ? ks[15-j] : ks[j]);
      l = t;
    end
    return {r, l};
  endfunction

  always_comb f_out = f_model(f_r, f_k);

  des_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .decrypt   (decrypt),
    .f_r       (f_r),
    .f_k       (f_k),
    .f_out     (f_out),
    .round_idx (round_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents a block, waits (bounded) for acceptance, then scrambles the inputs.
  task automatic send(input logic [1:64] d, input logic [1:64] k, input logic dec, output bit ok);
    int n;
    in_data  = d;
    in_key   = k;
    decrypt  = dec;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    ok = in_ready;
    if (ok) sb_q.push_back(ref_pre(d, k, dec));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom()};
    in_key   = {$urandom(), $urandom()};
    decrypt  = ~dec;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  function automatic logic [1:64] sb_pop();
    if (sb_q.size() == 0) return 'x;
    return sb_q.pop_front();
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_key = '0; decrypt = 1'b0;
    #3;
    n_checks++; if (in_ready !== 1'b1)   $display("FAIL reset in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0)  $display("FAIL reset out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 64'h0)  $display("FAIL reset out_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (round_idx !== 4'd0)  $display("FAIL reset round_idx: got %0d want 0", round_idx); else n_pass++;
    n_checks++; if (f_r !== 32'h0)       $display("FAIL reset f_r: got %h want 0", f_r); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1)   $display("FAIL reset release in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_encrypt();
    bit ok;
    int bad;
    logic [1:64] exp;
    out_ready = 1'b1;
    send(PT_A, KEY_A, 1'b0, ok);
    n_checks++; if (!ok) $display("FAIL enc accept: in_ready never rose"); else n_pass++;
    n_checks++; if (out_data !== 64'hF0AAF0AACC00CCFF) $display("FAIL enc IP load {R0,L0}: got %h want F0AAF0AACC00CCFF", out_data); else n_pass++;
    n_checks++; if (f_r !== 32'hF0AAF0AA) $display("FAIL enc f_r R0: got %h want F0AAF0AA", f_r); else n_pass++;
    n_checks++; if (f_k !== 48'h1B02EFFC7072) $display("FAIL enc K1: got %h want 1B02EFFC7072", f_k); else n_pass++;
    n_checks++; if (round_idx !== 4'd0) $display("FAIL enc round_idx r1: got %0d want 0", round_idx); else n_pass++;
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (round_idx !== 4'(k) || out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL enc round sequence: %0d bad cycles want 0", bad); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL enc latency: out_valid=%b after 16 edges want 1", out_valid); else n_pass++;
    exp = sb_pop();
    n_checks++; if (out_data !== exp) $display("FAIL enc scoreboard: got %h want %h", out_data, exp); else n_pass++;
    n_checks++; if (out_data !== 64'h0A4CD99543423234) $display("FAIL enc preout: got %h want 0A4CD99543423234", out_data); else n_pass++;
    n_checks++; if (fp_model(out_data) !== CT_A) $display("FAIL enc ciphertext: got %h want %h", fp_model(out_data), CT_A); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL enc in_ready in DONE: got %b want 0", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL enc return idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else n_pass++;
  endtask

  task automatic test_decrypt();
    bit ok;
    int cyc;
    logic [1:64] exp;
    out_ready = 1'b1;
    send(CT_A, KEY_A, 1'b1, ok);
    n_checks++; if (!ok) $display("FAIL dec accept: in_ready never rose"); else n_pass++;
    n_checks++; if (f_k !== 48'hCB3D8B0E17F5) $display("FAIL dec K16 first: got %h want CB3D8B0E17F5", f_k); else n_pass++;
    n_checks++; if (f_r !== 32'h43423234) $display("FAIL dec f_r R0: got %h want 43423234", f_r); else n_pass++;
    wait_out(cyc);
    n_checks++; if (cyc != 16) $display("FAIL dec latency: got %0d want 16", cyc); else n_pass++;
    exp = sb_pop();
    n_checks++; if (out_data !== exp) $display("FAIL dec scoreboard: got %h want %h", out_data, exp); else n_pass++;
    n_checks++; if (out_data !== 64'hCC00CCFFF0AAF0AA) $display("FAIL dec preout: got %h want CC00CCFFF0AAF0AA", out_data); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc, bad;
    logic [1:64] exp, d_b, k_b;
    d_b = 64'hFEDCBA9876543210;
    k_b = 64'h0F1571C947D9E859;
    out_ready = 1'b0;
    send(64'h1122334455667788, 64'hA1B2C3D4E5F60718, 1'b0, ok);
    n_checks++; if (!ok) $display("FAIL bp accept A: in_ready never rose"); else n_pass++;
    wait_out(cyc);
    n_checks++; if (cyc != 16) $display("FAIL bp latency A: got %0d want 16", cyc); else n_pass++;
    exp = (sb_q.size() > 0) ? sb_q[0] : 'x;
    in_data = d_b; in_key = k_b; decrypt = 1'b1; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL bp hold: %0d unstable cycles want 0", bad); else n_pass++;
    exp = sb_pop();
    n_checks++; if (out_data !== exp) $display("FAIL bp scoreboard A: got %h want %h", out_data, exp); else n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp idle after release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else n_pass++;
    send(d_b, k_b, 1'b1, ok);
    n_checks++; if (!ok) $display("FAIL bp accept B: in_ready never rose"); else n_pass++;
    wait_out(cyc);
    n_checks++; if (cyc != 16) $display("FAIL bp latency B: got %0d want 16", cyc); else n_pass++;
    exp = sb_pop();
    n_checks++; if (out_data !== exp) $display("FAIL bp scoreboard B: got %h want %h", out_data, exp); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    logic [1:64] exp;
    out_ready = 1'b1;
    send(64'hDEADBEEFCAFEF00D, 64'h3B3898371520F75E, 1'b0, ok);
    n_checks++; if (!ok) $display("FAIL rmid accept: in_ready never rose"); else n_pass++;
    repeat (7) @(posedge clk);
    #1;
    n_checks++; if (round_idx !== 4'd7) $display("FAIL rmid round_idx: got %0d want 7", round_idx); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1)  $display("FAIL rmid in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 64'h0) $display("FAIL rmid out_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (round_idx !== 4'd0) $display("FAIL rmid round_idx reset: got %0d want 0", round_idx); else n_pass++;
    n_checks++; if (f_r !== 32'h0)      $display("FAIL rmid f_r: got %h want 0", f_r); else n_pass++;
    sb_q = {};
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rmid release in_ready: got %b want 1", in_ready); else n_pass++;
    send(64'h0011223344556677, 64'h8899AABBCCDDEEFF, 1'b1, ok);
    n_checks++; if (!ok) $display("FAIL rmid fresh accept: in_ready never rose"); else n_pass++;
    wait_out(cyc);
    n_checks++; if (cyc != 16) $display("FAIL rmid fresh latency: got %0d want 16", cyc); else n_pass++;
    exp = sb_pop();
    n_checks++; if (out_data !== exp) $display("FAIL rmid fresh scoreboard: got %h want %h", out_data, exp); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [1:64] d [20];
    logic [1:64] k [20];
    logic        m [20];
    int          acc_cyc [20];
    int          idx, rcv, cyc, bad;
    bit          take, give;
    logic [1:64] exp;
    for (int i = 0; i < 20; i++) begin
      d[i] = {$urandom(), $urandom()};
      k[i] = {$urandom(), $urandom()};
      m[i] = (i % 2) == 1;
      acc_cyc[i] = 0;
    end
    out_ready = 1'b1;
    idx = 0; rcv = 0; cyc = 0;
    in_data = d[0]; in_key = k[0]; decrypt = m[0]; in_valid = 1'b1;
    while (rcv < 20 && cyc < 1000) begin
      take = in_ready && (idx < 20);
      give = out_valid;
      if (take) begin
        sb_q.push_back(ref_pre(d[idx], k[idx], m[idx]));
        acc_cyc[idx] = cyc;
      end
      if (give) begin
        exp = sb_pop();
        n_checks++; if (out_data !== exp) $display("FAIL b2b block %0d: got %h want %h", rcv, out_data, exp); else n_pass++;
        rcv++;
      end
      @(posedge clk); #1;
      cyc++;
      if (take) begin
        idx++;
        if (idx < 20) begin
          in_data = d[idx]; in_key = k[idx]; decrypt = m[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (rcv != 20) $display("FAIL b2b count: got %0d want 20", rcv); else n_pass++;
    bad = 0;
    for (int i = 1; i < 20; i++) if (acc_cyc[i] - acc_cyc[i-1] != 18) bad++;
    n_checks++; if (bad != 0) $display("FAIL b2b spacing: %0d gaps not 18 cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_parity();
    bit ok;
    int cyc;
    logic [1:64] key, data, exp, drop;
    key  = 64'h0E329232EA6D0D73;
    data = 64'h8787878787878787;
    exp  = ref_pre(data, key, 1'b0);
    out_ready = 1'b1;
    send(data, key, 1'b0, ok);
    n_checks++; if (!ok) $display("FAIL parity accept base: in_ready never rose"); else n_pass++;
    wait_out(cyc);
    drop = sb_pop();
    n_checks++; if (out_data !== exp) $display("FAIL parity base: got %h want %h", out_data, exp); else n_pass++;
    @(posedge clk); #1;
    send(data, key ^ 64'h0101010101010101, 1'b0, ok);
    n_checks++; if (!ok) $display("FAIL parity accept flipped: in_ready never rose"); else n_pass++;
    wait_out(cyc);
    drop = sb_pop();
    n_checks++; if (cyc != 16) $display("FAIL parity latency: got %0d want 16", cyc); else n_pass++;
    n_checks++; if (out_data !== exp) $display("FAIL parity flipped: got %h want %h", out_data, exp); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_parity();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Iterative DES round controller: the input end of the datapath whose output end is the existing inverse initial permutation.
- Accepts one 64-bit block plus key, applies the initial permutation (IP), and runs 16 Feistel rounds, one per clock, through an external combinational f-function.
- Delivers the pre-output R16‖L16, which feeds the inverse-IP permutation directly.
- Owns the key schedule (PC-1, rotations, PC-2) for both encrypt and decrypt.

## Interface
Parameters: none. All tables are fixed by FIPS 46-3.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  block/key/mode presented
- in_ready  out  1  high only in IDLE
- in_data  in  [1:64]  plaintext or ciphertext, bit 1 = MSB (DES numbering)
- in_key  in  [1:64]  key with parity bits 8,16,…,64, which are ignored
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at acceptance
- f_r  out  [1:32]  current R register, to f-function
- f_k  out  [1:48]  current round subkey, to f-function
- f_out  in  [1:32]  f(f_r, f_k), combinational, same cycle
- round_idx  out  4  current round minus 1 (0..15); 0 outside ROUND
- out_valid  out  1  pre-output valid
- out_ready  in  1  downstream accepts
- out_data  out  [1:64]  {R16, L16}

## Operation
States: IDLE → ROUND → DONE → IDLE.
- **IDLE:** in_ready=1. On in_valid&&in_ready:
  - {L,R} ← IP(in_data); {C,D} ← PC-1(in_key); mode ← decrypt; rnd ← 0; go to ROUND.
- **ROUND:** each cycle: L ← R; R ← L ^ f_out; {C,D} ← rotated value used for this round's subkey; rnd ← rnd+1.
  - After rnd=15: go to DONE.
- **Subkey, encrypt:** round j (1..16) rotates C and D left by s[j], with s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. f_k = PC-2(rotated C,D).
- **Subkey, decrypt:** round j uses K(17−j).
  - j=1: no rotation, because total encrypt rotation is 28 (identity).
  - j≥2: rotate C and D right by s[18−j].
  - f_k = PC-2(rotated C,D).
- **DONE:** out_valid=1, out_data={R,L}, both held stable until out_ready. On out_valid&&out_ready: go to IDLE.
- No overlap: a new block is never accepted in DONE.
- in_data and in_key are not retained after acceptance; inputs changing during ROUND have no effect.
- Reset (asynchronous, any state, including mid-round):
  - state=IDLE; L, R, C, D, rnd, mode = 0.
  - Outputs: out_valid=0, out_data=0, round_idx=0, f_r=0, in_ready=1. The in-flight block is dropped.

## Timing
- Acceptance edge E0. Rounds 1..16 execute on edges E1..E16. out_valid rises after E16 (16-cycle latency).
- If out_ready is held high: handshake at E17, IDLE after E17, next accept at E18 at the earliest. Minimum 18 cycles per block.
- out_ready low: DONE holds indefinitely; out_data is stable throughout.
- f_out is sampled the same cycle f_r/f_k are driven. No pipeline register exists in the f path.
- in_ready, out_valid, and round_idx are decoded from registered state. They have no combinational path from in_valid or out_ready.

## Structure
- **Shared package des_pkg:**
  - IP, PC-1, PC-2 index tables.
  - Shift schedule s[1..16].
  - State enum {IDLE, ROUND, DONE}.
  - Widths DES_BLK=64, DES_HALF=32, DES_CD=28, DES_SUBKEY=48.
- **Sub-module des_key_sched:**
  - Holds C/D and computes rotation and PC-2.
  - Inputs: load, step, mode, rnd.
  - Output: f_k.
- **des_round_ctrl** keeps the FSM, IP, and L/R registers.
- The f-function (E, S-boxes, P) stays external.

## Test plan
The bench uses a behavioural f-function model.
- **Encrypt:** key 133457799BBCDFF1, in_data 0123456789ABCDEF, decrypt=0 → after E0, L=CC00CCFF, R=F0AAF0AA; round 1 f_k=1B02EFFC7072; out_data=0A4CD99543423234 after exactly 16 cycles; inverse-IP of that = 85E813540F0AB405.
- **Decrypt:** same key, in_data 85E813540F0AB405, decrypt=1 → round 1 f_k=CB3D8B0E17F5 (K16); out_data=CC00CCFFF0AAF0AA.
- **Backpressure:** out_ready held low 10 cycles after out_valid → out_valid and out_data stable, in_ready=0, second in_valid ignored. Release → handshake, then IDLE, then second block accepted and processed correctly.
- **Reset mid-operation:** rst_n low at rnd=7 → outputs go to reset values immediately without a clock. After release, in_ready=1 and a fresh block gives the correct result.
- **Back-to-back stream:** in_valid and out_ready always high, 20 random key/blocks (half decrypt) → each matches the reference model; acceptances exactly 18 cycles apart.
- **Parity independence:** flip key bits 8,16,…,64 → identical out_data.
